// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_NOP_INS  = 32'h0000_0000;

  // Fetch FSM encoding, kept as plain constants for older tool flows.
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t REQ  = 2'd1;
  localparam state_t DROP = 2'd2;

  // One buffered fetch result: the address it came from and the word returned.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_if.sv
// Bundle of the fetch stage's memory handshake, redirect input and IF/ID head outputs.
interface if_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        wr_IF2ID;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic        ins_valid;

  modport master (
    output imem_req, imem_addr, ins_out, pc_out, ins_valid,
    input  imem_ack, imem_rdata, redirect, redirect_pc, wr_IF2ID
  );

  modport slave (
    input  imem_req, imem_addr, ins_out, pc_out, ins_valid,
    output imem_ack, imem_rdata, redirect, redirect_pc, wr_IF2ID
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, ins} entries; flush beats push.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents only matter where the pointers say they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, runs the imem req/ack handshake,
// buffers returned words and presents the head entry to IF/ID.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP_INS  = DEFAULT_NOP_INS
) (
  input  logic  clk,
  input  logic  reset,
  if_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t         state;
  logic [31:0]    fetch_pc;
  logic [31:0]    req_addr;
  logic [31:0]    target;
  logic [31:0]    pc_plus4;
  logic           push;
  logic           pop;
  logic           empty;
  logic           full;
  logic           has_room;
  logic [CW-1:0]  count;
  logic [CW-1:0]  occ_next;
  fetch_entry_t   head;
  fetch_entry_t   din;

  assign target   = {bus.redirect_pc[31:2], 2'b00};
  assign pc_plus4 = fetch_pc + 32'd4;
  assign push     = (state == REQ) && bus.imem_ack && !bus.redirect && !full;
  assign pop      = !empty && bus.wr_IF2ID && !bus.redirect;
  assign din      = '{pc: req_addr, ins: bus.imem_rdata};
  assign has_room = (occ_next < CW'(DEPTH));

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   (din),
    .head  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // Buffer occupancy after this edge's push/pop, used to decide whether to keep requesting.
  always_comb begin
    occ_next = count;
    if (bus.redirect) begin
      occ_next = '0;
    end else begin
      if (push) occ_next = occ_next + CW'(1);
      if (pop)  occ_next = occ_next - CW'(1);
    end
  end

  // Fetch FSM: an issued request cannot be withdrawn, so a redirect while waiting goes through DROP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (bus.redirect) begin
            fetch_pc <= target;
          end else if (has_room) begin
            state    <= REQ;
            req_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (bus.redirect) begin
            fetch_pc <= target;
            if (bus.imem_ack) req_addr <= target;
            else              state    <= DROP;
          end else if (bus.imem_ack) begin
            fetch_pc <= pc_plus4;
            if (has_room) req_addr <= pc_plus4;
            else          state    <= IDLE;
          end
        end
        DROP: begin
          if (bus.redirect) fetch_pc <= target;
          if (bus.imem_ack) begin
            state    <= REQ;
            req_addr <= bus.redirect ? target : fetch_pc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req  = (state == REQ) || (state == DROP);
  assign bus.imem_addr = req_addr;
  assign bus.ins_valid = !empty;
  assign bus.ins_out   = empty ? NOP_INS : head.ins;
  assign bus.pc_out    = empty ? fetch_pc : head.pc;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: program-order reference model feeding a
// scoreboard queue, directed scenarios followed by randomized traffic.
module tb_if_fetch;

  localparam logic [31:0] RST_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

  logic clk = 1'b0;
  logic reset;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RST_PC), .DEPTH(2), .NOP_INS(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Memory model: the word at an address is the address scrambled with a fixed key.
  assign bus.imem_rdata = bus.imem_addr ^ XOR_KEY;

  int total = 0;
  int bad = 0;
  int delivered = 0;
  int starve = 0;
  int base;

  // Expected program-order stream of PCs that IF/ID should receive.
  logic [31:0] exp_q[$];
  logic [31:0] model_next;
  logic [31:0] mon_pc;

  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_reset = 1'b1;
  logic [31:0] prev_addr = '0;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
    end
  endtask

  function void model_fill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(model_next);
      model_next = model_next + 32'd4;
    end
  endfunction

  function void model_restart(input logic [31:0] pc);
    exp_q.delete();
    model_next = pc;
    model_fill();
  endfunction

  task automatic apply_stimulus(input logic rst, input logic ack, input logic wr,
                                input logic redir, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset           = rst;
    bus.imem_ack    = ack;
    bus.wr_IF2ID    = wr;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    if (rst)        model_restart(RST_PC);
    else if (redir) model_restart({rpc[31:2], 2'b00});
  endtask

  task automatic wait_req(input logic wr);
    for (int i = 0; i < 20 && !bus.imem_req; i++) apply_stimulus(1'b0, 1'b0, wr, 1'b0, '0);
    check_output("wait_req", {31'b0, bus.imem_req}, 32'd1);
  endtask

  // Monitor: compares the IF/ID head against the model and checks the handshake holds.
  always @(negedge clk) begin
    if (!reset) begin
      if (!bus.redirect) begin
        check_output("head_pc", bus.pc_out, exp_q[0]);
        if (!bus.ins_valid) check_output("empty_nop", bus.ins_out, NOP);
        if (bus.ins_valid && bus.wr_IF2ID) begin
          mon_pc = exp_q.pop_front();
          model_fill();
          check_output("pop_ins", bus.ins_out, mon_pc ^ XOR_KEY);
          delivered++;
          starve = 0;
        end else if (bus.wr_IF2ID) begin
          starve++;
          if (starve > 40) begin
            total++;
            bad++;
            $display("[TB] FAIL progress: got %0d idle cycles want <=40", starve);
            starve = 0;
          end
        end
      end else begin
        starve = 0;
      end
      if (prev_req && !prev_ack && !prev_reset) begin
        check_output("req_hold", {31'b0, bus.imem_req}, 32'd1);
        check_output("addr_hold", bus.imem_addr, prev_addr);
      end
    end else begin
      starve = 0;
    end
    prev_req   = bus.imem_req;
    prev_ack   = bus.imem_ack;
    prev_reset = reset;
    prev_addr  = bus.imem_addr;
  end

  // Directed scenarios, then randomized traffic, then the summary.
  initial begin
    logic        r_rst, r_ack, r_wr, r_red;
    logic [31:0] r_pc;
    reset           = 1'b1;
    bus.imem_ack    = 1'b0;
    bus.wr_IF2ID    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    model_restart(RST_PC);

    // Reset values
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check_output("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check_output("rst_valid", {31'b0, bus.ins_valid}, 32'd0);
    check_output("rst_ins", bus.ins_out, NOP);
    check_output("rst_pc", bus.pc_out, RST_PC);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check_output("rel_req", {31'b0, bus.imem_req}, 32'd1);
    check_output("rel_addr", bus.imem_addr, RST_PC);
    check_output("rel_valid", {31'b0, bus.ins_valid}, 32'd0);
    check_output("rel_ins", bus.ins_out, NOP);

    // Streaming at one instruction per cycle
    for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
    base = delivered;
    for (int i = 0; i < 16; i++) apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check_output("stream_rate", 32'(delivered - base), 32'd16);

    // Stall: buffer fills to DEPTH and requests stop
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    base = delivered;
    @(negedge clk);
    check_output("stall_req", {31'b0, bus.imem_req}, 32'd0);
    check_output("stall_valid", {31'b0, bus.ins_valid}, 32'd1);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    check_output("stall_drain", 32'(delivered - base), 32'd2);

    // Redirect while a request is outstanding
    wait_req(1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0103);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    check_output("drop_req", {31'b0, bus.imem_req}, 32'd1);
    check_output("drop_valid", {31'b0, bus.ins_valid}, 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    check_output("redir_addr", bus.imem_addr, 32'h8000_0100);
    check_output("redir_valid", {31'b0, bus.ins_valid}, 32'd0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    check_output("redir_head", bus.pc_out, 32'h8000_0100);

    // Redirect with same-cycle ack
    wait_req(1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0200);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
    @(negedge clk);
    check_output("same_addr", bus.imem_addr, 32'h8000_0200);
    check_output("same_valid", {31'b0, bus.ins_valid}, 32'd0);

    // Reset while in DROP
    wait_req(1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h8000_0300);
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check_output("mrst_req", {31'b0, bus.imem_req}, 32'd0);
    check_output("mrst_pc", bus.pc_out, RST_PC);
    check_output("mrst_addr", bus.imem_addr, RST_PC);

    // Address wrap at the top of memory
    wait_req(1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(negedge clk);
    check_output("wrap_addr", bus.imem_addr, 32'h0000_0000);
    check_output("wrap_head", bus.pc_out, 32'hFFFF_FFFC);

    // Randomized traffic
    base = delivered;
    for (int i = 0; i < 800; i++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_ack = ($urandom_range(0, 99) < 55);
      r_wr  = ($urandom_range(0, 99) < 75);
      r_red = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 9) == 0) r_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else                           r_pc = 32'h8000_0000 | 32'($urandom_range(0, 4095));
      apply_stimulus(r_rst, r_ack, r_wr, r_red, r_pc);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_output("random_progress", {31'b0, (delivered - base) >= 150}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and runs a req/ack handshake to instruction memory, tolerating variable memory latency. Returned words are held in a small fetch buffer, and the head entry (instruction + PC) is presented to IF/ID. Branch/jump redirects from ID flush the buffer and restart fetch at the target.

Parameters:
RESET_PC, 32'h8000_0000, fetch address after reset; must match the IF/ID reset PC.
DEPTH, 2, fetch buffer entries (power of 2, ≥2).
NOP_INS, 32'h0000_0000, instruction driven when the buffer is empty.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
imem_req  output  1  memory request; held high until acknowledged
imem_addr  output  32  request address; stable while imem_req=1
imem_ack  input  1  completes the request this cycle; imem_rdata valid
imem_rdata  input  32  instruction word
redirect  input  1  branch/jump taken (same cycle as the IF/ID flush)
redirect_pc  input  32  redirect target; bits [1:0] forced to 0
wr_IF2ID  input  1  IF/ID write enable (0 = stall)
ins_out  output  32  head instruction; NOP_INS when empty
pc_out  output  32  head PC; equals fetch_pc when empty
ins_valid  output  1  buffer not empty

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, and it wins over every other input.
- Reset values: fetch_pc=RESET_PC, req_addr=RESET_PC, state=IDLE, buffer empty, imem_req=0, ins_valid=0, ins_out=NOP_INS, pc_out=RESET_PC.
- Registers:
  - fetch_pc: next address to request.
  - req_addr: address of the outstanding request; drives imem_addr.
  - state: IDLE / REQ / DROP.
  - imem_req=1 in REQ and DROP.
- Handshake: the request completes on any clk edge where imem_req=1 and imem_ack=1. Memory latency is ≥0 cycles after the request is asserted. imem_ack is ignored while in IDLE.
- Pop: on an edge where ins_valid=1 and wr_IF2ID=1. Push: on REQ completion without redirect; the entry is {req_addr, imem_rdata}.
- occ_next = occupancy after this edge's push and pop.
- FSM transitions:
  - IDLE → REQ when occ_next + 0 < DEPTH. Load req_addr=fetch_pc.
  - REQ on ack, no redirect: push; fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC → 0).
    - If occ_next < DEPTH: stay in REQ with req_addr = new fetch_pc (back-to-back, 1 ins/cycle sustained).
    - Else: go to IDLE.
  - REQ without ack: hold req_addr.
  - REQ + redirect with ack: data discarded. Flush the buffer; fetch_pc = req_addr = redirect_pc; stay in REQ.
  - REQ + redirect without ack: go to DROP; fetch_pc = redirect_pc; req_addr unchanged (request cannot be withdrawn).
  - DROP on ack: discard data; go to REQ with req_addr = fetch_pc.
  - DROP + redirect: update fetch_pc only.
  - IDLE + redirect: fetch_pc = redirect_pc; next cycle behaves as IDLE with the new PC.
- Redirect semantics: redirect flushes the entire buffer, including the head. A pop in the same cycle is irrelevant, since IF/ID is flushed that cycle. Redirect takes priority over push and pop.
- Output timing: no combinational path from imem_rdata to ins_out. Data reaches IF/ID one edge after ack at the earliest.
- Buffer boundaries:
  - Full buffer: no new request is issued.
  - Empty buffer with wr_IF2ID=1: IF/ID loads NOP_INS; no pop.

Decomposition:
- Package if_pkg holds:
  - the state enum (IDLE, REQ, DROP);
  - the RESET_PC and NOP_INS defaults;
  - the fetch-entry struct {pc[31:0], ins[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO with DEPTH entries of 64 bits, with push, pop and flush inputs and count/empty/full outputs. Flush takes priority over push.

Test Plan:
- Reset: assert reset 2 cycles, release → imem_req=1 with imem_addr=0x8000_0000 in the first cycle after release; ins_valid=0, ins_out=0.
- Streaming: ack every cycle with rdata=addr^0xA5A5A5A5, wr_IF2ID=1 → pc_out sequence 0x8000_0000, _0004, _0008… at 1/cycle with matching ins_out.
- Stall: wr_IF2ID=0 for 5 cycles, ack always 1 → exactly DEPTH entries buffered, then imem_req=0. On release, the buffered PCs are delivered in order with no gap or duplication.
- Redirect in flight: request at 0x8000_0008, ack delayed 3 cycles, redirect to 0x8000_0103 → DROP state; the stale data is never visible. The next request is at 0x8000_0100, which becomes the next pc_out.
- Redirect with same-cycle ack: redirect to 0x8000_0200 while ack=1 → acked data discarded, buffer empty, next imem_addr=0x8000_0200.
- Mid-operation reset, plus wrap: reset during DROP → IDLE/RESET_PC state next cycle. Separately, redirect to 0xFFFF_FFFC → next fetch address is 0x0000_0000.
